// File: rtl/ripple_mon_pkg.sv
// ============================================================================
// Module  : ripple_mon_pkg
// Brief   : Shared defaults and types for the ripple counter monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ripple_mon_pkg;

    localparam int RCM_WIDTH   = 4;
    localparam int RCM_EPOCH_W = 8;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } rcm_state_t;

    typedef struct packed {
        logic [RCM_WIDTH-1:0]   value;
        logic [RCM_EPOCH_W-1:0] epoch;
    } rcm_rec_t;

endpackage

`default_nettype wire

// File: rtl/rcm_sync.sv
// ============================================================================
// Module  : rcm_sync
// Brief   : WIDTH-bit two-flop synchronizer, synchronous active-low reset.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rcm_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_s1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1 <= '0;
            q    <= '0;
        end else begin
            r_s1 <= d;
            q    <= r_s1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ripple_count_monitor.sv
// ============================================================================
// Module  : ripple_count_monitor
// Brief   : Tracks a ripple counter in the clk domain; emits value/epoch
//           records, a compare-match pulse and a sticky overrun flag.
//           Optional macro RCM_GLITCH_FILTER_EN adds a stability filter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ripple_count_monitor
    import ripple_mon_pkg::*;
#(
    parameter int WIDTH   = RCM_WIDTH,
    parameter int EPOCH_W = RCM_EPOCH_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   cnt_in,
    input  logic [WIDTH-1:0]   cmp_val,
    input  logic               ovr_clr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_value,
    output logic [EPOCH_W-1:0] out_epoch,
    output logic               match,
    output logic               overrun
);

    logic [WIDTH-1:0]   w_s2;
    logic               w_accept;
    logic               w_change;
    logic               w_wrap;
    logic               w_fire;
    logic [EPOCH_W-1:0] w_epoch_next;

    rcm_state_t         r_state;
    logic [WIDTH-1:0]   r_cur;
    logic [EPOCH_W-1:0] r_epoch;

    rcm_sync #(
        .WIDTH (WIDTH)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (cnt_in),
        .q     (w_s2)
    );

`ifdef RCM_GLITCH_FILTER_EN
    // A code must survive two consecutive samples before it is trusted.
    logic [WIDTH-1:0] r_s3;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s3 <= '0;
        end else begin
            r_s3 <= w_s2;
        end
    end

    assign w_accept = (w_s2 == r_s3);
`else
    assign w_accept = 1'b1;
`endif

    assign w_change     = (r_state == RUN) && w_accept && (w_s2 != r_cur);
    assign w_wrap       = (w_s2 < r_cur);
    assign w_epoch_next = (w_wrap && (r_epoch != {EPOCH_W{1'b1}})) ?
                          r_epoch + EPOCH_W'(1) : r_epoch;
    assign w_fire       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= INIT;
            r_cur     <= '0;
            r_epoch   <= '0;
            out_valid <= 1'b0;
            out_value <= '0;
            out_epoch <= '0;
            match     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            match <= 1'b0;
            case (r_state)
                INIT: begin
                    if (w_accept) begin
                        r_cur   <= w_s2;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_change) begin
                        r_cur   <= w_s2;
                        r_epoch <= w_epoch_next;
                        match   <= (w_s2 == cmp_val);
                    end
                end
                default: r_state <= INIT;
            endcase

            // Single-entry buffer: a draining entry may be replaced on the same edge.
            if (w_change && (!out_valid || w_fire)) begin
                out_valid <= 1'b1;
                out_value <= w_s2;
                out_epoch <= w_epoch_next;
            end else if (w_fire) begin
                out_valid <= 1'b0;
            end

            if (w_change && out_valid && !w_fire) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ripple_count_monitor.sv
// ============================================================================
// Module  : tb_ripple_count_monitor
// Brief   : Self-checking bench for ripple_count_monitor (honours
//           RCM_GLITCH_FILTER_EN when defined).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ripple_count_monitor;
    import ripple_mon_pkg::*;

    localparam int W = RCM_WIDTH;
    localparam int E = RCM_EPOCH_W;
`ifdef RCM_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] cnt_in;
    logic [W-1:0] cmp_val;
    logic         ovr_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_value;
    logic [E-1:0] out_epoch;
    logic         match;
    logic         overrun;

    int total = 0;
    int bad   = 0;

    logic [W+E-1:0] got_q[$];
    logic [W+E-1:0] exp_q[$];
    int m_cur;
    int m_epoch;

    always #5 clk = ~clk;

    ripple_count_monitor dut (
        .clk       (clk),
        .reset     (reset),
        .cnt_in    (cnt_in),
        .cmp_val   (cmp_val),
        .ovr_clr   (ovr_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_epoch (out_epoch),
        .match     (match),
        .overrun   (overrun)
    );

    // Records are taken at the falling edge, ahead of the handshake edge.
    always @(negedge clk) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
            got_q.push_back({out_value, out_epoch});
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        reset     = 1'b0;
        cnt_in    = '0;
        ovr_clr   = 1'b0;
        out_ready = 1'b0;
        step(3);
        reset   = 1'b1;
        m_cur   = 0;
        m_epoch = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    // Reference: every held value that differs from the last one is a record;
    // a decrease is a wrap, and the epoch saturates at all-ones.
    task automatic hold(input int v, input int n);
        cnt_in = W'(v);
        step(n);
        if (v != m_cur) begin
            if (v < m_cur && m_epoch < (1 << E) - 1) m_epoch++;
            exp_q.push_back({W'(v), E'(m_epoch)});
            m_cur = v;
        end
    endtask

    task automatic test_reset;
        do_reset();
        total++;
        if ({out_valid, out_value, out_epoch, match, overrun} !== '0) begin
            bad++;
            $display("FAIL reset_state got v=%b val=%h ep=%h m=%b ov=%b required all 0",
                     out_valid, out_value, out_epoch, match, overrun);
        end
    endtask

    task automatic test_first_load;
        do_reset();
        cmp_val = 4'd1;
        cnt_in  = 4'd0;
        step(6);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL first_load_norecord got valid=%b required 0", out_valid);
        end
        cnt_in = 4'd1;
        for (int k = 1; k <= LAT; k++) begin
            step(1);
            total++;
            if (k < LAT && out_valid !== 1'b0) begin
                bad++;
                $display("FAIL latency_early edge=%0d got valid=%b required 0", k, out_valid);
            end else if (k == LAT && {out_valid, match, out_value, out_epoch} !== {1'b1, 1'b1, 4'd1, 8'd0}) begin
                bad++;
                $display("FAIL latency_record got v=%b m=%b val=%h ep=%h required v=1 m=1 val=1 ep=0",
                         out_valid, match, out_value, out_epoch);
            end
        end
    endtask

    task automatic test_sweep;
        do_reset();
        out_ready = 1'b1;
        for (int v = 1; v <= 15; v++) hold(v, 4);
        hold(0, 4);
        step(6);
        total++;
        if (got_q.size() != 16 || exp_q.size() != 16) begin
            bad++;
            $display("FAIL sweep_count got=%0d required=16", got_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL sweep_rec%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
        if (got_q.size() > 0) begin
            total++;
            if (got_q[got_q.size()-1] !== {4'd0, 8'd1}) begin
                bad++;
                $display("FAIL sweep_wrap_epoch got=%h required=001", got_q[got_q.size()-1]);
            end
        end
    endtask

    task automatic test_match;
        int pulses;
        logic prev;
        do_reset();
        cmp_val   = 4'd9;
        out_ready = 1'b1;
        pulses    = 0;
        prev      = 1'b0;
        for (int v = 1; v <= 15; v++) begin
            cnt_in = W'(v);
            for (int k = 0; k < 4; k++) begin
                step(1);
                if (match === 1'b1) begin
                    pulses++;
                    total++;
                    if (!(out_valid === 1'b1 && out_value === 4'd9) || prev === 1'b1) begin
                        bad++;
                        $display("FAIL match_align got valid=%b val=%h prev=%b required valid=1 val=9 prev=0",
                                 out_valid, out_value, prev);
                    end
                end
                prev = match;
            end
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL match_count got=%0d required=1", pulses);
        end
    endtask

    task automatic test_overrun;
        do_reset();
        hold(3, 5);
        hold(5, 5);
        total++;
        if ({out_valid, out_value, overrun} !== {1'b1, 4'd3, 1'b1}) begin
            bad++;
            $display("FAIL overrun_drop got v=%b val=%h ov=%b required v=1 val=3 ov=1",
                     out_valid, out_value, overrun);
        end
        ovr_clr = 1'b1;
        step(1);
        ovr_clr = 1'b0;
        total++;
        if ({overrun, out_value} !== {1'b0, 4'd3}) begin
            bad++;
            $display("FAIL overrun_clear got ov=%b val=%h required ov=0 val=3", overrun, out_value);
        end
        out_ready = 1'b1;
        step(1);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain got valid=%b required 0", out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_glitch;
        do_reset();
        out_ready = 1'b1;
        hold(7, 5);
        cnt_in = 4'hF;
        step(1);
`ifndef RCM_GLITCH_FILTER_EN
        exp_q.push_back({4'hF, E'(m_epoch)});
        m_cur = 15;
`endif
        hold(8, 6);
        step(4);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL glitch_count got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL glitch_rec%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_midreset;
        do_reset();
        out_ready = 1'b1;
        hold(5, 5);
        hold(2, 5);
        out_ready = 1'b0;
        cnt_in    = 4'd4;
        step(5);
        total++;
        if ({out_valid, out_epoch} !== {1'b1, 8'd1}) begin
            bad++;
            $display("FAIL midreset_pre got v=%b ep=%h required v=1 ep=01", out_valid, out_epoch);
        end
        reset  = 1'b0;
        cnt_in = 4'd0;
        step(1);
        total++;
        if ({out_valid, out_epoch, match, overrun} !== '0) begin
            bad++;
            $display("FAIL midreset_clear got v=%b ep=%h m=%b ov=%b required all 0",
                     out_valid, out_epoch, match, overrun);
        end
        step(2);
        reset   = 1'b1;
        m_cur   = 0;
        m_epoch = 0;
        got_q.delete();
        exp_q.delete();
        out_ready = 1'b1;
        hold(3, 6);
        total++;
        if (got_q.size() != 1 || exp_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            bad++;
            $display("FAIL midreset_post got n=%0d rec=%h required n=1 rec=300",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : '0);
        end
    endtask

    task automatic test_random;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++)
            hold(int'($urandom_range(0, 15)), int'($urandom_range(3, 6)));
        step(6);
        total++;
        if (got_q.size() != exp_q.size() || overrun !== 1'b0) begin
            bad++;
            $display("FAIL random_count got=%0d ov=%b required=%0d ov=0",
                     got_q.size(), overrun, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL random_rec%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_saturation;
        do_reset();
        out_ready = 1'b1;
        repeat (260) begin
            hold(8, 3);
            hold(1, 3);
        end
        step(6);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL sat_count got=%0d required=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL sat_rec%0d got=%h required=%h", i, got_q[i], exp_q[i]);
            end
        end
        if (got_q.size() > 0) begin
            total++;
            if (got_q[got_q.size()-1] !== {4'd1, 8'hFF}) begin
                bad++;
                $display("FAIL sat_last got=%h required=1ff", got_q[got_q.size()-1]);
            end
        end
    endtask

    initial begin
        reset     = 1'b0;
        cnt_in    = '0;
        cmp_val   = '0;
        ovr_clr   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_first_load();
        test_sweep();
        test_match();
        test_overrun();
        test_glitch();
        test_midreset();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
